// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback formatter for an RV64I core.
// Captures memory-stage results and aligns plus sign/zero-extends load data.
// Selects the writeback source and drives the register file write port.
// Also keeps a retired-instruction counter and a load-fault flag.
// Ports:
//   clk, reset (async, active-low)
//   in_valid, stall, flush                      - pipeline control
//   RegWrite_in, WbSel_in, funct3_in, RD_in     - instruction control from MEM
//   ALUResult_in (also load address), MemData_in, PCPlus4_in - datapath from MEM
//   RegWrite, RD, WriteData                     - register file write port (registered)
//   wb_valid, load_fault, retire_count          - status (registered)
module mem_wb_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             RegWrite_in,
    input  logic [1:0]       WbSel_in,
    input  logic [2:0]       funct3_in,
    input  logic [4:0]       RD_in,
    input  logic [XLEN-1:0]  ALUResult_in,
    input  logic [XLEN-1:0]  MemData_in,
    input  logic [XLEN-1:0]  PCPlus4_in,
    output logic             RegWrite,
    output logic [4:0]       RD,
    output logic [XLEN-1:0]  WriteData,
    output logic             wb_valid,
    output logic             load_fault,
    output logic [CNT_W-1:0] retire_count
);

    localparam int unsigned RD_W     = 5;
    localparam logic [1:0]  SEL_ALU  = 2'b00;
    localparam logic [1:0]  SEL_LOAD = 2'b01;
    localparam logic [1:0]  SEL_PC4  = 2'b10;

    logic [2:0]       off;
    logic [5:0]       shamt;
    logic [XLEN-1:0]  shifted;
    logic             load_fault_c;
    logic [XLEN-1:0]  load_data_c;
    logic [XLEN-1:0]  wb_data_c;
    logic             fault_cap_c;

    logic             reg_write_d, reg_write_q;
    logic [RD_W-1:0]  rd_d, rd_q;
    logic [XLEN-1:0]  write_data_d, write_data_q;
    logic             wb_valid_d, wb_valid_q;
    logic             load_fault_d, load_fault_q;
    logic [CNT_W-1:0] retire_count_d, retire_count_q;

    // Load alignment: shift the addressed byte lane down to bit 0, then extend.
    always_comb begin
        off          = ALUResult_in[2:0];
        shamt        = {off, 3'b000};
        shifted      = MemData_in >> shamt;
        load_fault_c = 1'b0;
        load_data_c  = '0;
        case (funct3_in)
            3'b000: load_data_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001: begin
                load_fault_c = off[0];
                load_data_c  = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            3'b010: begin
                load_fault_c = |off[1:0];
                load_data_c  = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            end
            3'b011: begin
                load_fault_c = |off;
                load_data_c  = shifted;
            end
            3'b100: load_data_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101: begin
                load_fault_c = off[0];
                load_data_c  = {{(XLEN-16){1'b0}}, shifted[15:0]};
            end
            3'b110: begin
                load_fault_c = |off[1:0];
                load_data_c  = {{(XLEN-32){1'b0}}, shifted[31:0]};
            end
            default: load_fault_c = 1'b1;
        endcase
        if (load_fault_c) begin
            load_data_c = '0;
        end
    end

    // Writeback source select; the reserved encoding produces zero.
    always_comb begin
        wb_data_c = '0;
        case (WbSel_in)
            SEL_ALU:  wb_data_c = ALUResult_in;
            SEL_LOAD: wb_data_c = load_data_c;
            SEL_PC4:  wb_data_c = PCPlus4_in;
            default:  wb_data_c = '0;
        endcase
    end

    assign fault_cap_c = in_valid & (WbSel_in == SEL_LOAD) & load_fault_c;

    // Next-state: flush beats stall beats capture.
    always_comb begin
        reg_write_d    = reg_write_q;
        rd_d           = rd_q;
        write_data_d   = write_data_q;
        wb_valid_d     = wb_valid_q;
        load_fault_d   = load_fault_q;
        retire_count_d = retire_count_q;
        if (flush) begin
            reg_write_d  = 1'b0;
            rd_d         = '0;
            write_data_d = '0;
            wb_valid_d   = 1'b0;
            load_fault_d = 1'b0;
        end else if (!stall) begin
            wb_valid_d   = in_valid;
            rd_d         = RD_in;
            write_data_d = wb_data_c;
            load_fault_d = fault_cap_c;
            reg_write_d  = in_valid & RegWrite_in & (RD_in != '0)
                         & ~fault_cap_c & (WbSel_in != 2'b11);
            if (in_valid) begin
                retire_count_d = retire_count_q + CNT_W'(1);
            end
        end
    end

    // WB pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_q    <= 1'b0;
            rd_q           <= '0;
            write_data_q   <= '0;
            wb_valid_q     <= 1'b0;
            load_fault_q   <= 1'b0;
            retire_count_q <= '0;
        end else begin
            reg_write_q    <= reg_write_d;
            rd_q           <= rd_d;
            write_data_q   <= write_data_d;
            wb_valid_q     <= wb_valid_d;
            load_fault_q   <= load_fault_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign RegWrite     = reg_write_q;
    assign RD           = rd_q;
    assign WriteData    = write_data_q;
    assign wb_valid     = wb_valid_q;
    assign load_fault   = load_fault_q;
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage; a second instance with a
// 3-bit retire counter exercises counter wrap-around.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic        RegWrite_in;
    logic [1:0]  WbSel_in;
    logic [2:0]  funct3_in;
    logic [4:0]  RD_in;
    logic [63:0] ALUResult_in;
    logic [63:0] MemData_in;
    logic [63:0] PCPlus4_in;

    logic        RegWrite,   w_RegWrite;
    logic [4:0]  RD,         w_RD;
    logic [63:0] WriteData,  w_WriteData;
    logic        wb_valid,   w_wb_valid;
    logic        load_fault, w_load_fault;
    logic [63:0] retire_count;
    logic [2:0]  w_retire_count;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .RegWrite_in(RegWrite_in), .WbSel_in(WbSel_in), .funct3_in(funct3_in),
        .RD_in(RD_in), .ALUResult_in(ALUResult_in), .MemData_in(MemData_in),
        .PCPlus4_in(PCPlus4_in), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .wb_valid(wb_valid), .load_fault(load_fault), .retire_count(retire_count)
    );

    mem_wb_stage #(.CNT_W(3)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .RegWrite_in(RegWrite_in), .WbSel_in(WbSel_in), .funct3_in(funct3_in),
        .RD_in(RD_in), .ALUResult_in(ALUResult_in), .MemData_in(MemData_in),
        .PCPlus4_in(PCPlus4_in), .RegWrite(w_RegWrite), .RD(w_RD), .WriteData(w_WriteData),
        .wb_valid(w_wb_valid), .load_fault(w_load_fault), .retire_count(w_retire_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        flt;
        logic [4:0]  rd;
        logic [63:0] wd;
        logic [63:0] cnt;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference load formatter built byte by byte from the memory word.
    function automatic logic [63:0] fmt_load(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] mem, output logic flt);
        int          off;
        int          nb;
        logic        sext;
        logic [63:0] r;
        off  = int'(addr[2:0]);
        sext = 1'b0;
        case (f3)
            3'd0: begin nb = 1; sext = 1'b1; end
            3'd1: begin nb = 2; sext = 1'b1; end
            3'd2: begin nb = 4; sext = 1'b1; end
            3'd3: nb = 8;
            3'd4: nb = 1;
            3'd5: nb = 2;
            3'd6: nb = 4;
            default: nb = 0;
        endcase
        flt = (nb == 0) || ((off % nb) != 0);
        r   = '0;
        if (!flt) begin
            for (int i = 0; i < nb; i++) r[8*i +: 8] = mem[8*(off+i) +: 8];
            if (sext && nb < 8 && r[8*nb-1]) begin
                for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
            end
        end
        return r;
    endfunction

    task automatic set_in(input logic v, input logic rw, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] alu,
                          input logic [63:0] mem, input logic [63:0] pc);
        in_valid = v; RegWrite_in = rw; WbSel_in = sel; funct3_in = f3;
        RD_in = rd; ALUResult_in = alu; MemData_in = mem; PCPlus4_in = pc;
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        check_eq({tag, ".valid"}, 64'(wb_valid),   64'(e.v));
        check_eq({tag, ".rw"},    64'(RegWrite),   64'(e.rw));
        check_eq({tag, ".fault"}, 64'(load_fault), 64'(e.flt));
        check_eq({tag, ".rd"},    64'(RD),         64'(e.rd));
        check_eq({tag, ".wd"},    WriteData,       e.wd);
        check_eq({tag, ".cnt"},   retire_count,    e.cnt);
        check_eq({tag, ".w_rw"},  64'(w_RegWrite), 64'(e.rw));
        check_eq({tag, ".w_v"},   64'(w_wb_valid), 64'(e.v));
        check_eq({tag, ".w_flt"}, 64'(w_load_fault), 64'(e.flt));
        check_eq({tag, ".w_rd"},  64'(w_RD),       64'(e.rd));
        check_eq({tag, ".w_wd"},  w_WriteData,     e.wd);
        check_eq({tag, ".w_cnt"}, 64'(w_retire_count), 64'(e.cnt[2:0]));
    endtask

    // Apply current inputs for one edge: model predicts, scoreboard compares.
    task automatic step(input string tag);
        exp_t        e;
        logic        lf;
        logic [63:0] ld;
        logic        is_ld;
        ld    = fmt_load(funct3_in, ALUResult_in, MemData_in, lf);
        is_ld = (WbSel_in == 2'b01);
        if (flush) begin
            m.v = 1'b0; m.rw = 1'b0; m.flt = 1'b0; m.rd = '0; m.wd = '0;
        end else if (!stall) begin
            m.v   = in_valid;
            m.rd  = RD_in;
            case (WbSel_in)
                2'b00:   m.wd = ALUResult_in;
                2'b01:   m.wd = lf ? 64'h0 : ld;
                2'b10:   m.wd = PCPlus4_in;
                default: m.wd = '0;
            endcase
            m.flt = in_valid && is_ld && lf;
            m.rw  = in_valid && RegWrite_in && (RD_in != 5'd0) && !(is_ld && lf)
                    && (WbSel_in != 2'b11);
            if (in_valid) m.cnt = m.cnt + 64'd1;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp_out(tag, e);
    endtask

    localparam logic [63:0] MEMW = 64'h8899AABBCCDDEEFF;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m        = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        reset    = 1'b0;
        set_in(1'b1, 1'b1, 2'b00, 3'b011, 5'd9, 64'hDEAD, MEMW, 64'h44);

        // Asynchronous reset before any clock edge.
        #2;
        check_eq("rst.rw",  64'(RegWrite), 64'h0);
        check_eq("rst.rd",  64'(RD),       64'h0);
        check_eq("rst.wd",  WriteData,     64'h0);
        check_eq("rst.v",   64'(wb_valid), 64'h0);
        check_eq("rst.flt", 64'(load_fault), 64'h0);
        check_eq("rst.cnt", retire_count,  64'h0);

        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        step("bubble");

        @(negedge clk);
        set_in(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 64'h1234, 64'h0, 64'h0);
        step("alu");
        check_eq("alu.rw_k",  64'(RegWrite), 64'h1);
        check_eq("alu.rd_k",  64'(RD),       64'h5);
        check_eq("alu.wd_k",  WriteData,     64'h1234);
        check_eq("alu.cnt_k", retire_count,  64'h1);

        @(negedge clk); set_in(1'b1, 1'b1, 2'b01, 3'b000, 5'd6, 64'h1001, MEMW, 64'h0);
        step("lb");  check_eq("lb.k",  WriteData, 64'hFFFFFFFFFFFFFFEE);
        @(negedge clk); set_in(1'b1, 1'b1, 2'b01, 3'b100, 5'd6, 64'h1001, MEMW, 64'h0);
        step("lbu"); check_eq("lbu.k", WriteData, 64'h00000000000000EE);
        @(negedge clk); set_in(1'b1, 1'b1, 2'b01, 3'b010, 5'd6, 64'h1004, MEMW, 64'h0);
        step("lw");  check_eq("lw.k",  WriteData, 64'hFFFFFFFF8899AABB);
        @(negedge clk); set_in(1'b1, 1'b1, 2'b01, 3'b110, 5'd6, 64'h1004, MEMW, 64'h0);
        step("lwu"); check_eq("lwu.k", WriteData, 64'h000000008899AABB);
        @(negedge clk); set_in(1'b1, 1'b1, 2'b01, 3'b011, 5'd6, 64'h1000, MEMW, 64'h0);
        step("ld");  check_eq("ld.k",  WriteData, 64'h8899AABBCCDDEEFF);

        @(negedge clk); set_in(1'b1, 1'b1, 2'b01, 3'b001, 5'd7, 64'h1003, MEMW, 64'h0);
        step("lh_mis");
        check_eq("lh_mis.flt_k", 64'(load_fault), 64'h1);
        check_eq("lh_mis.rw_k",  64'(RegWrite),   64'h0);
        check_eq("lh_mis.wd_k",  WriteData,       64'h0);
        @(negedge clk); set_in(1'b1, 1'b1, 2'b01, 3'b111, 5'd7, 64'h1000, MEMW, 64'h0);
        step("ill");
        check_eq("ill.flt_k", 64'(load_fault), 64'h1);
        check_eq("ill.rw_k",  64'(RegWrite),   64'h0);

        @(negedge clk); set_in(1'b1, 1'b1, 2'b00, 3'b000, 5'd0, 64'h77, MEMW, 64'h0);
        step("x0");
        check_eq("x0.rw_k",  64'(RegWrite), 64'h0);
        check_eq("x0.v_k",   64'(wb_valid), 64'h1);
        check_eq("x0.cnt_k", retire_count,  64'h9);
        @(negedge clk); set_in(1'b1, 1'b1, 2'b11, 3'b111, 5'd3, 64'h1003, MEMW, 64'h0);
        step("sel11");
        check_eq("sel11.rw_k",  64'(RegWrite),   64'h0);
        check_eq("sel11.flt_k", 64'(load_fault), 64'h0);
        @(negedge clk); set_in(1'b1, 1'b1, 2'b10, 3'b000, 5'd1, 64'h5, MEMW, 64'h10000004);
        step("pc4");
        check_eq("pc4.wd_k", WriteData, 64'h10000004);

        // Stall for three cycles while inputs keep changing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            set_in(1'b1, 1'b1, 2'(i), 3'(i), 5'(i + 10), {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom});
            step("stall");
        end
        check_eq("stall.wd_k",  WriteData,      64'h10000004);
        check_eq("stall.cnt_k", retire_count,   64'd11);
        check_eq("wrap.cnt_k",  64'(w_retire_count), 64'd3);

        @(negedge clk); flush = 1'b1; stall = 1'b1;
        step("flush_stall");
        check_eq("fs.v_k",   64'(wb_valid), 64'h0);
        check_eq("fs.rw_k",  64'(RegWrite), 64'h0);
        check_eq("fs.cnt_k", retire_count,  64'd11);

        // Reset asserted in the middle of a stall clears immediately.
        @(negedge clk); flush = 1'b0; stall = 1'b0;
        set_in(1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 64'h55, MEMW, 64'h0);
        step("pre_rst");
        @(negedge clk); stall = 1'b1;
        #1 reset = 1'b0;
        #1;
        m = '0;
        cmp_out("mid_rst", m);
        #1 reset = 1'b1;
        stall = 1'b0;
        set_in(1'b1, 1'b1, 2'b00, 3'b000, 5'd7, 64'hABCD, MEMW, 64'h0);
        step("post_rst");
        check_eq("post_rst.cnt_k", retire_count, 64'd1);
        check_eq("post_rst.wd_k",  WriteData,    64'hABCD);

        // Randomised traffic across all controls.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            set_in(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 3'($urandom),
                   5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom});
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
